// File: rtl/time_counter_hms.sv
// time_counter_hms: BCD hh:mm:ss time-of-day counter driven by a 1 s tick, with validated load and carry pulses
module time_counter_hms #(
  parameter int MAX_HOUR  = 23,
  parameter bit TICK_EDGE = 1'b1
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       sig_1s,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       load_err
);
  localparam logic [7:0] hour_max = 8'(((MAX_HOUR / 10) << 4) | (MAX_HOUR % 10));

  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic       sig_prev_q, load_err_q, load_err_d;
  logic       sec_q, sec_d, min_q, min_d, hour_q, hour_d, day_q, day_d;
  logic       tick, cnt, load_ok;
  logic [8:0] s, m, h;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= lim;
  endfunction

  // {carry, next}: a non-BCD or out-of-range field recovers to 00 without carrying
  function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] lim, input logic en);
    return !bcd_ok(v, lim) ? 9'h000 :
           !en             ? {1'b0, v} :
           v == lim        ? 9'h100 :
           v[3:0] == 4'd9  ? {1'b0, v[7:4] + 4'd1, 4'd0} :
                             {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    tick       = TICK_EDGE ? (sig_1s & ~sig_prev_q) : (~sig_1s & sig_prev_q);
    cnt        = tick & run & ~load;
    s          = bcd_step(ss_q, 8'h59, 1'b1);
    m          = bcd_step(mm_q, 8'h59, s[8]);
    h          = bcd_step(hh_q, hour_max, m[8]);
    load_ok    = bcd_ok(load_hh, hour_max) & bcd_ok(load_mm, 8'h59) & bcd_ok(load_ss, 8'h59);
    ss_d       = load ? (load_ok ? load_ss : ss_q) : cnt ? s[7:0] : ss_q;
    mm_d       = load ? (load_ok ? load_mm : mm_q) : cnt ? m[7:0] : mm_q;
    hh_d       = load ? (load_ok ? load_hh : hh_q) : cnt ? h[7:0] : hh_q;
    load_err_d = load ? ~load_ok : load_err_q;
    sec_d      = cnt;
    min_d      = cnt & s[8];
    hour_d     = cnt & m[8];
    day_d      = cnt & h[8];
  end

  always_ff @(posedge clk_50MHz) begin
    sig_prev_q <= sig_1s;
    if (!rst) begin
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      load_err_q <= 1'b0;
      sec_q      <= 1'b0;
      min_q      <= 1'b0;
      hour_q     <= 1'b0;
      day_q      <= 1'b0;
    end else begin
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      load_err_q <= load_err_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
    end
  end

  assign hh_bcd     = hh_q;
  assign mm_bcd     = mm_q;
  assign ss_bcd     = ss_q;
  assign sec_pulse  = sec_q;
  assign min_pulse  = min_q;
  assign hour_pulse = hour_q;
  assign day_pulse  = day_q;
  assign load_err   = load_err_q;
endmodule

// File: tb/tb_time_counter_hms.sv
// tb_time_counter_hms: three counter variants (23h rising, 11h rising, 23h falling) against a seconds-of-day model
module tb_time_counter_hms;
  logic clk = 1'b0;
  logic rst, sig, run, load;
  logic [7:0] lhh, lmm, lss;
  logic [7:0] hh [3], mm [3], ss [3];
  logic sp [3], mp [3], hp [3], dp [3], le [3];
  int total = 0, bad = 0, spc = 0, casc = 0, anyp = 0;

  int   maxh [3] = '{23, 11, 23};
  bit   eg   [3] = '{1'b1, 1'b1, 1'b0};
  int   t    [3];
  logic [3:0] pl [3];
  logic er [3], pv [3];

  always #10 clk = ~clk;

  time_counter_hms #(.MAX_HOUR(23), .TICK_EDGE(1'b1)) dut0 (
    .clk_50MHz(clk), .rst(rst), .sig_1s(sig), .run(run), .load(load),
    .load_hh(lhh), .load_mm(lmm), .load_ss(lss),
    .hh_bcd(hh[0]), .mm_bcd(mm[0]), .ss_bcd(ss[0]),
    .sec_pulse(sp[0]), .min_pulse(mp[0]), .hour_pulse(hp[0]), .day_pulse(dp[0]), .load_err(le[0]));
  time_counter_hms #(.MAX_HOUR(11), .TICK_EDGE(1'b1)) dut1 (
    .clk_50MHz(clk), .rst(rst), .sig_1s(sig), .run(run), .load(load),
    .load_hh(lhh), .load_mm(lmm), .load_ss(lss),
    .hh_bcd(hh[1]), .mm_bcd(mm[1]), .ss_bcd(ss[1]),
    .sec_pulse(sp[1]), .min_pulse(mp[1]), .hour_pulse(hp[1]), .day_pulse(dp[1]), .load_err(le[1]));
  time_counter_hms #(.MAX_HOUR(23), .TICK_EDGE(1'b0)) dut2 (
    .clk_50MHz(clk), .rst(rst), .sig_1s(sig), .run(run), .load(load),
    .load_hh(lhh), .load_mm(lmm), .load_ss(lss),
    .hh_bcd(hh[2]), .mm_bcd(mm[2]), .ss_bcd(ss[2]),
    .sec_pulse(sp[2]), .min_pulse(mp[2]), .hour_pulse(hp[2]), .day_pulse(dp[2]), .load_err(le[2]));

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input int mx);
    return b[7:4] <= 4'd9 && b[3:0] <= 4'd9 && from_bcd(b) <= mx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: time kept as seconds since midnight, day length from MAX_HOUR
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int day = (maxh[k] + 1) * 3600;
      bit tk = eg[k] ? (sig && !pv[k]) : (!sig && pv[k]);
      pv[k] = sig;
      pl[k] = 4'b0000;
      if (!rst) begin
        t[k] = 0;
        er[k] = 1'b0;
      end else if (load) begin
        if (field_ok(lhh, maxh[k]) && field_ok(lmm, 59) && field_ok(lss, 59)) begin
          t[k] = from_bcd(lhh) * 3600 + from_bcd(lmm) * 60 + from_bcd(lss);
          er[k] = 1'b0;
        end else er[k] = 1'b1;
      end else if (tk && run) begin
        pl[k] = {1'b1, t[k] % 60 == 59, t[k] % 3600 == 3599, t[k] == day - 1};
        t[k] = (t[k] + 1) % day;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("state%0d", k),
          {3'b0, hh[k], mm[k], ss[k], sp[k], mp[k], hp[k], dp[k], le[k]},
          {3'b0, to_bcd(t[k] / 3600), to_bcd(t[k] / 60 % 60), to_bcd(t[k] % 60), pl[k], er[k]});
    spc  += int'(sp[0]);
    casc += int'(mp[0] & hp[0] & dp[0]);
    anyp += int'(mp[0] | hp[0] | dp[0]);
  endtask

  task automatic tick1();
    sig = 1'b1; step();
    sig = 1'b0; step();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    lhh = h; lmm = m; lss = s; load = 1'b1; step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sig = 1'b1; run = 1'b1; load = 1'b0; lhh = 8'h00; lmm = 8'h00; lss = 8'h00;
    for (int k = 0; k < 3; k++) begin t[k] = 0; pl[k] = 4'b0; er[k] = 1'b0; pv[k] = 1'b1; end
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    chk("held_hi_time", {8'h0, hh[0], mm[0], ss[0]}, 32'h0);
    chk("held_hi_nosec", spc, 0);
    sig = 1'b0; step();
    spc = 0;
    repeat (5) tick1();
    chk("five_ticks_ss", ss[0], 8'h05);
    chk("five_ticks_sec", spc, 5);
    spc = 0; sig = 1'b1;
    repeat (20) step();
    sig = 1'b0; step();
    chk("wide_pulse", spc, 1);
    do_load(8'h23, 8'h59, 8'h58);
    casc = 0; anyp = 0;
    tick1();
    chk("cascade_pre", {8'h0, hh[0], mm[0], ss[0]}, 32'h235959);
    tick1();
    chk("cascade_time", {8'h0, hh[0], mm[0], ss[0]}, 32'h0);
    chk("cascade_same", casc, 1);
    chk("cascade_once", anyp, 1);
    do_load(8'h12, 8'h6A, 8'h00);
    chk("bad_load_err", le[0], 1);
    chk("bad_load_time", {8'h0, hh[0], mm[0], ss[0]}, 32'h0);
    do_load(8'h01, 8'h02, 8'h03);
    chk("good_load_err", le[0], 0);
    chk("good_load_time", {8'h0, hh[0], mm[0], ss[0]}, 32'h010203);
    run = 1'b0;
    repeat (3) tick1();
    chk("paused", ss[0], 8'h03);
    run = 1'b1;
    tick1();
    chk("resume", ss[0], 8'h04);
    sig = 1'b1; lhh = 8'h05; lmm = 8'h06; lss = 8'h07; load = 1'b1; step();
    load = 1'b0;
    chk("load_tick", {8'h0, hh[0], mm[0], ss[0], 7'b0, sp[0]}, 32'h05060700);
    sig = 1'b0; step();
    do_load(8'h11, 8'h59, 8'h59);
    sig = 1'b1; step();
    chk("max11_wrap", {7'h0, hh[1], mm[1], ss[1], dp[1]}, 32'h1);
    sig = 1'b0; step();
    do_load(8'h23, 8'h59, 8'h59);
    sig = 1'b1; rst = 1'b0; step();
    chk("rst_cascade", {3'h0, hh[0], mm[0], ss[0], sp[0], mp[0], hp[0], dp[0], le[0]}, 32'h0);
    rst = 1'b1; sig = 1'b0; step();
    for (int i = 0; i < 3000; i++) begin
      rst  = $urandom_range(0, 199) != 0;
      run  = $urandom_range(0, 9) != 0;
      sig  = ($urandom_range(0, 2) == 0) ? ~sig : sig;
      load = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 2) == 0) begin
        lhh = 8'($urandom); lmm = 8'($urandom); lss = 8'($urandom);
      end else begin
        lhh = to_bcd($urandom_range(0, 1) ? 23 : ($urandom_range(0, 1) ? 11 : $urandom_range(0, 23)));
        lmm = to_bcd($urandom_range(0, 1) ? 59 : $urandom_range(0, 59));
        lss = to_bcd($urandom_range(50, 59));
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
